// File: rtl/subtrator_serial_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The requester drives start and the operands; the subtractor returns status and the result.
interface subtrator_serial_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a, b, borrow_in,
    input  ready, busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b, borrow_in,
    output ready, busy, done, diff, borrow_out
  );
endinterface

// File: rtl/subtrator_serial.sv
// Bit-serial subtractor: diff = a - b - borrow_in, one full-subtractor step per clock, LSB first.
// The result and final borrow are published only when all WIDTH bits are complete.
module subtrator_serial #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  subtrator_serial_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-2:0] res;       // partial result; the final bit goes straight into diff_q
  logic             br;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;

  logic             d;
  logic             br_next;
  logic [WIDTH-1:0] res_next;

  always_comb begin
    d        = sh_a[0] ^ sh_b[0] ^ br;
    br_next  = (~sh_a[0] & sh_b[0]) | (~(sh_a[0] ^ sh_b[0]) & br);
    res_next = {d, res};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; the shift chain would collapse into one cycle with blocking ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sh_a     <= '0;
      sh_b     <= '0;
      res      <= '0;
      br       <= 1'b0;
      cnt      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sh_a  <= bus.a;
            sh_b  <= bus.b;
            br    <= bus.borrow_in;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sh_a <= sh_a >> 1;
          sh_b <= sh_b >> 1;
          br   <= br_next;
          res  <= res_next[WIDTH-1:1];
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            diff_q   <= res_next;
            borrow_q <= br_next;
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready      = (state == IDLE);
  assign bus.busy       = (state == RUN);
  assign bus.done       = (state == DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;
endmodule
